fifo_decrypt_reader: RTL and testbench
======================================

// Module: fifo_decrypt_reader
// PURPOSE
//  Read-side consumer for the encrypted 128-bit FIFO. Pops ciphertext words (1-cycle registered read
//  latency), XOR-decrypts them with a key latched at burst start, and presents plaintext on a
//  valid/ready stream. Bursts of N words run on a start command, with a last flag, a done pulse and a
//  delivered-word counter.
// PARAMETERS
//  DATA_W     128  word / key width
//  BUF_DEPTH  2    output buffer entries (>=2 for full throughput)
//  LEN_W      8    burst length width
//  CNT_W      16   delivered-word counter width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  secret_key    in   DATA_W   decrypt key, sampled only on accepted start_i
//  start_i       in   1        begin burst (accepted only in IDLE)
//  burst_len_i   in   LEN_W    words in burst; 0 => start ignored
//  busy_o        out  1        high in any state except IDLE
//  done_o        out  1        1-cycle pulse after final word handshake
//  fifo_empty_i  in   1        FIFO empty flag
//  fifo_rd_en_o  out  1        FIFO pop request
//  fifo_data_i   in   DATA_W   ciphertext, valid the cycle after fifo_rd_en_o
//  m_valid_o     out  1        plaintext word available
//  m_ready_i     in   1        consumer accepts word
//  m_data_o      out  DATA_W   plaintext = ciphertext ^ key_q
//  m_last_o      out  1        qualifies final word of burst
//  words_out_o   out  CNT_W    total words delivered since reset, wraps
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; buffer and in-flight flag cleared; key_q = 0. Reset mid-burst
//   aborts the burst; a word popped in the previous cycle is discarded.
//  FSM: IDLE -(start_i & burst_len_i!=0)-> RUN. RUN -(all N reads issued)-> DRAIN.
//   DRAIN -(Nth m handshake)-> DONE. DONE -> IDLE (unconditional, done_o=1 in DONE only).
//   If N reads are issued and the Nth handshake happens in the same cycle, RUN goes straight to DONE.
//  On accepted start: key_q <= secret_key; issue_cnt <= N; deliver_cnt <= N. Later secret_key changes
//   have no effect on the burst.
//  Read issue: fifo_rd_en_o = RUN & !fifo_empty_i & issue_cnt!=0 & (occ+inflight < BUF_DEPTH
//   | (pop & occ+inflight == BUF_DEPTH)). pop = m_valid_o & m_ready_i. Never pops an empty FIFO.
//  Latency: rd_en in cycle T -> data written into buffer at end of T+1 (XOR applied on write)
//   -> m_valid_o=1 in T+2. First word: start in cycle 0, rd_en in cycle 1, m_valid_o in cycle 3.
//  Throughput: with the FIFO never empty and m_ready_i=1, 1 word/cycle sustained.
//  Stream rule: once m_valid_o=1, m_data_o/m_last_o hold until handshake. Buffer is in-order.
//   A simultaneous write and pop is legal at any occupancy, including full.
//  m_last_o=1 iff head word is the burst's final word (deliver_cnt==1).
//  words_out_o increments on each handshake; wraps 2^CNT_W-1 -> 0.
//  start_i while busy_o=1 is ignored; it is not queued.
//  FIFO empty mid-burst: stall issue and resume when not empty. No timeout.
// STRUCTURE
//  Shared package fifo_crypt_pkg: DATA_W, state encoding (IDLE, RUN, DRAIN, DONE), xor_crypt function
//   (shared with the encrypt side).
//  Sub-module reader_out_buf: BUF_DEPTH-entry sync FIFO {last, data} with occ count and
//   simultaneous push/pop. Top holds the FSM, counters, key_q and issue logic.
// TESTING
//  1 Key 128'h0F..0F, FIFO holds {A5..A5, 00..00}, N=2, ready=1 -> data AA..AA then 0F..0F;
//    last on 2nd word; done_o pulse; words_out_o=2.
//  2 N=4, FIFO full, ready=1 -> rd_en in cycles 1-4, valid in cycles 3-6 back-to-back, 4 handshakes.
//  3 N=3, ready toggles 1/0 -> data/last stable while stalled; buffer occupancy never exceeds
//    BUF_DEPTH; no rd_en while fifo_empty_i=1.
//  4 Change secret_key mid-burst -> output still uses the key latched at start; start_i pulses while
//    busy have no effect.
//  5 FIFO empties after word 1 of N=3 and refills 10 cycles later -> burst completes in order;
//    burst_len_i=0 start leaves busy_o=0.
//  6 rst=1 during DRAIN with m_valid_o=1 -> next cycle all outputs 0, IDLE; words_out_o wraps
//    FFFF->0000 when preloaded by a long run.

Source files
------------

// File: rtl/fifo_crypt_pkg.sv
// Shared definitions for the encrypted-FIFO writer and reader: word width, reader FSM
// states and the XOR cipher used on both sides.
package fifo_crypt_pkg;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  function automatic logic [DATA_W-1:0] xor_crypt(input logic [DATA_W-1:0] data,
                                                  input logic [DATA_W-1:0] key);
    return data ^ key;
  endfunction
endpackage

// File: rtl/reader_out_buf.sv
// Small in-order output buffer holding {last, data}; push and pop may coincide at any occupancy.
// Head is available the cycle after the push; overflow is prevented by the producer.
module reader_out_buf #(
  parameter int W     = 129,
  parameter int DEPTH = 2,
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [OW-1:0] occ_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [OW-1:0] occ_q;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop     = pop_i & (occ_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign occ_o      = occ_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + OW'(push_i) - OW'(do_pop);
    end
  end
endmodule

// File: rtl/fifo_decrypt_reader.sv
// Burst reader for the encrypted FIFO: pops ciphertext, XORs with the burst key, streams plaintext.
// First word valid 3 cycles after start; issue throttles on buffer space and FIFO empty.
module fifo_decrypt_reader #(
  parameter int DATA_W    = fifo_crypt_pkg::DATA_W,
  parameter int BUF_DEPTH = 2,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] secret_key,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [CNT_W-1:0]  words_out_o
);
  import fifo_crypt_pkg::*;

  localparam int OW = $clog2(BUF_DEPTH + 1);

  state_e            state_q;
  logic [DATA_W-1:0] key_q;
  logic [LEN_W-1:0]  issue_cnt_q, deliver_cnt_q;
  logic              inflight_q, inflight_last_q;
  logic [CNT_W-1:0]  words_q;

  logic [OW-1:0]     occ;
  logic [OW:0]       pend;
  logic [DATA_W:0]   head;
  logic              pop;

  // Words already committed to the buffer: stored plus the one arriving from the FIFO.
  assign pend = {1'b0, occ} + {{OW{1'b0}}, inflight_q};
  assign pop  = m_valid_o & m_ready_i;

  assign fifo_rd_en_o = (state_q == ST_RUN) & ~fifo_empty_i & (issue_cnt_q != '0) &
                        ((pend < (OW+1)'(BUF_DEPTH)) | (pop & (pend == (OW+1)'(BUF_DEPTH))));

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign words_out_o = words_q;
  assign m_valid_o   = (occ != '0);
  assign m_last_o    = m_valid_o & head[DATA_W];
  assign m_data_o    = m_valid_o ? head[DATA_W-1:0] : '0;

  reader_out_buf #(
    .W     (DATA_W + 1),
    .DEPTH (BUF_DEPTH),
    .OW    (OW)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_dat_i ({inflight_last_q, xor_crypt(fifo_data_i, key_q)}),
    .pop_i      (pop),
    .head_dat_o (head),
    .occ_o      (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      key_q           <= '0;
      issue_cnt_q     <= '0;
      deliver_cnt_q   <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      words_q         <= '0;
    end else begin
      inflight_q      <= fifo_rd_en_o;
      inflight_last_q <= fifo_rd_en_o & (issue_cnt_q == LEN_W'(1));
      if (fifo_rd_en_o) issue_cnt_q <= issue_cnt_q - LEN_W'(1);
      if (pop) begin
        deliver_cnt_q <= deliver_cnt_q - LEN_W'(1);
        words_q       <= words_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i && burst_len_i != '0) begin
            key_q         <= secret_key;
            issue_cnt_q   <= burst_len_i;
            deliver_cnt_q <= burst_len_i;
            state_q       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fifo_rd_en_o && issue_cnt_q == LEN_W'(1))
            state_q <= (pop && deliver_cnt_q == LEN_W'(1)) ? ST_DONE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && deliver_cnt_q == LEN_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_decrypt_reader.sv
// Bench for fifo_decrypt_reader: FIFO model plus a word-order reference model of the
// plaintext stream, busy/done timing and the delivered-word counter.
module tb_fifo_decrypt_reader;
  localparam int DW = 128, DEPTH = 2, LW = 8, CW = 16;

  logic          clk, rst;
  logic [DW-1:0] secret_key;
  logic          start_i;
  logic [LW-1:0] burst_len_i;
  logic          busy_o, done_o;
  logic          fifo_empty_i, fifo_rd_en_o;
  logic [DW-1:0] fifo_data_i;
  logic          m_valid_o, m_ready_i, m_last_o;
  logic [DW-1:0] m_data_o;
  logic [CW-1:0] words_out_o;

  fifo_decrypt_reader #(.DATA_W(DW), .BUF_DEPTH(DEPTH), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .secret_key(secret_key), .start_i(start_i),
    .burst_len_i(burst_len_i), .busy_o(busy_o), .done_o(done_o),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o), .fifo_data_i(fifo_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .words_out_o(words_out_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] cipher_log[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] key_m;
  logic [DW-1:0] prev_dat;
  logic          prev_last, prev_stall;
  logic          exp_busy, exp_done;
  logic [CW-1:0] exp_words;
  int popped, hs_idx, remaining, issued, delivered;
  int checks, failures;
  int rel, lat_n, ready_mode;
  bit chk_on, lat_on, autofill;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    cipher_log.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic tick();
    logic rd_s, hs, accepted, done_next;
    @(negedge clk);
    if (chk_on && !rst) begin
      chk("busy", busy_o, exp_busy);
      chk("done", done_o, exp_done);
      chk("words_out", words_out_o, exp_words);
      chk("rd_while_empty", fifo_rd_en_o & fifo_empty_i, 1'b0);
      chk("occ_bound", (issued - delivered) <= DEPTH, 1'b1);
      if (prev_stall) begin
        chk("stall_valid", m_valid_o, 1'b1);
        chk("stall_data", m_data_o, prev_dat);
        chk("stall_last", m_last_o, prev_last);
      end
      if (lat_on) begin
        chk("lat_rd", fifo_rd_en_o, (rel >= 1 && rel <= lat_n));
        chk("lat_valid", m_valid_o, (rel >= 3 && rel <= lat_n + 2));
      end
    end
    rd_s = fifo_rd_en_o;
    hs   = m_valid_o & m_ready_i;
    if (hs && chk_on && !rst) begin
      chk("hs_in_burst", remaining > 0, 1'b1);
      chk("data", m_data_o, cipher_log[hs_idx] ^ key_m);
      chk("last", m_last_o, remaining == 1);
      obs_q.push_back(m_data_o);
    end
    accepted   = !rst && start_i && !exp_busy && (burst_len_i != '0);
    prev_stall = m_valid_o & ~m_ready_i & ~rst;
    prev_dat   = m_data_o;
    prev_last  = m_last_o;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) begin
      fifo_data_i = fifo_q.pop_front();
      popped++;
    end else begin
      fifo_data_i = rnd128();
    end
    if (rst) begin
      exp_busy = 1'b0; exp_done = 1'b0; exp_words = '0;
      remaining = 0; issued = 0; delivered = 0;
      hs_idx = popped; prev_stall = 1'b0;
    end else begin
      if (rd_s) issued++;
      done_next = hs && (remaining == 1);
      if (hs) begin
        hs_idx++; remaining--; delivered++; exp_words++;
      end
      if (exp_done) exp_busy = 1'b0;
      exp_done = done_next;
      if (accepted) begin
        exp_busy = 1'b1; key_m = secret_key;
        remaining = int'(burst_len_i); issued = 0; delivered = 0;
      end
    end
    if (autofill) while (fifo_q.size() < 4) push_word(rnd128());
    fifo_empty_i = (fifo_q.size() == 0);
    if (ready_mode == 1) m_ready_i = ~m_ready_i;
    else if (ready_mode == 2) m_ready_i = 1'($urandom_range(0, 1));
    rel++;
  endtask

  task automatic start_burst(input int len);
    start_i = 1'b1;
    burst_len_i = LW'(len);
    rel = 0;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_busy; i++) tick();
    tick();
    chk("burst_finished", busy_o, 1'b0);
    lat_on = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_valid"}, m_valid_o, 1'b0);
    chk({tag, "_rd"}, fifo_rd_en_o, 1'b0);
    chk({tag, "_data"}, m_data_o, '0);
    chk({tag, "_last"}, m_last_o, 1'b0);
    chk({tag, "_words"}, words_out_o, '0);
  endtask

  initial begin
    checks = 0; failures = 0; popped = 0; hs_idx = 0; remaining = 0;
    issued = 0; delivered = 0; rel = 0; lat_n = 0; ready_mode = 0;
    chk_on = 0; lat_on = 0; autofill = 0;
    exp_busy = 0; exp_done = 0; exp_words = '0; key_m = '0;
    prev_stall = 0; prev_dat = '0; prev_last = 0;
    rst = 1'b1; secret_key = '0; start_i = 1'b0; burst_len_i = '0;
    fifo_empty_i = 1'b1; fifo_data_i = '0; m_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_zero_outputs("reset");
    chk_on = 1;

    // 1: known-answer burst
    secret_key = {16{8'h0F}};
    push_word({16{8'hA5}});
    push_word('0);
    obs_q.delete();
    lat_on = 1; lat_n = 2;
    start_burst(2);
    wait_idle(20);
    chk("t1_count", obs_q.size(), 2);
    chk("t1_word0", obs_q[0], {16{8'hAA}});
    chk("t1_word1", obs_q[1], {16{8'h0F}});
    chk("t1_words_out", words_out_o, 16'd2);

    // 2: full-rate burst, cycle-exact issue and valid windows
    secret_key = rnd128();
    for (int i = 0; i < 4; i++) push_word(rnd128());
    lat_on = 1; lat_n = 4;
    start_burst(4);
    wait_idle(20);

    // 3: consumer toggles ready
    secret_key = rnd128();
    for (int i = 0; i < 3; i++) push_word(rnd128());
    ready_mode = 1;
    start_burst(3);
    wait_idle(40);
    ready_mode = 0; m_ready_i = 1'b1;

    // 4: key change and start pulses mid-burst, random ready
    secret_key = rnd128();
    for (int i = 0; i < 4; i++) push_word(rnd128());
    ready_mode = 2;
    start_burst(4);
    tick();
    secret_key = rnd128();
    start_i = 1'b1; burst_len_i = 8'd3;
    tick();
    start_i = 1'b0;
    secret_key = rnd128();
    wait_idle(60);
    ready_mode = 0; m_ready_i = 1'b1;

    // 5: FIFO runs dry after the first word, refills later
    secret_key = rnd128();
    push_word(rnd128());
    start_burst(3);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_stalled_busy", busy_o, 1'b1);
    push_word(rnd128());
    push_word(rnd128());
    wait_idle(30);
    start_i = 1'b1; burst_len_i = '0;
    tick();
    start_i = 1'b0;
    tick();
    chk("t5_len0_idle", busy_o, 1'b0);

    // 6: reset while draining, then counter wrap
    secret_key = rnd128();
    push_word(rnd128());
    push_word(rnd128());
    m_ready_i = 1'b0;
    start_burst(2);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_busy_before_rst", busy_o, 1'b1);
    chk("t6_valid_before_rst", m_valid_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero_outputs("mid_rst");
    m_ready_i = 1'b1;
    autofill = 1;
    for (int b = 0; b < 257; b++) begin
      secret_key = rnd128();
      start_burst(255);
      wait_idle(400);
    end
    chk("pre_wrap", words_out_o, 16'hFFFF);
    secret_key = rnd128();
    start_burst(2);
    wait_idle(20);
    chk("post_wrap", words_out_o, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
